// File: rtl/c1541_sd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : c1541_sd_arb
//  Description : Round-robin arbiter that lets NUM_DRIVES per-drive track
//                buffer ports share a single host SD sector channel. Routes
//                ack / buffer strobe / write data for the granted drive only,
//                and aborts a request that the host never acknowledges.
//  Ports       :
//    clk_sys, reset_n            clock, async active-low reset
//    drv_lba/drv_rd/drv_wr       per-drive sector requests (level, held)
//    drv_ack/drv_buff_wr         per-drive ack and read-data strobe
//    drv_buff_din                per-drive write data toward the host
//    drv_err                     per-drive one-cycle timeout abort pulse
//    sd_lba/sd_rd/sd_wr          request presented to the host
//    sd_ack/sd_buff_wr           host ack and read-data strobe
//    sd_buff_din                 write data muxed from the granted drive
//    sd_drive/sd_busy            granted index, arbiter not idle
//  Revision    : 1.0  initial release
// ============================================================================
module c1541_sd_arb #(
    parameter int          NUM_DRIVES = 4,
    parameter int          IDX_W      = 2,
    parameter int unsigned TIMEOUT    = 24'hFFFFFF
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [32*NUM_DRIVES-1:0] drv_lba,
    input  logic [NUM_DRIVES-1:0]   drv_rd,
    input  logic [NUM_DRIVES-1:0]   drv_wr,
    output logic [NUM_DRIVES-1:0]   drv_ack,
    output logic [NUM_DRIVES-1:0]   drv_buff_wr,
    input  logic [8*NUM_DRIVES-1:0] drv_buff_din,
    output logic [NUM_DRIVES-1:0]   drv_err,
    output logic [31:0]             sd_lba,
    output logic                    sd_rd,
    output logic                    sd_wr,
    input  logic                    sd_ack,
    input  logic                    sd_buff_wr,
    output logic [7:0]              sd_buff_din,
    output logic [IDX_W-1:0]        sd_drive,
    output logic                    sd_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last timer value at which the host may still answer before abort.
    localparam logic [23:0] c_TO_LAST = 24'(TIMEOUT - 1);
    localparam logic [23:0] c_TMR_MAX = 24'hFFFFFF;

    state_t                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]        r_drive, w_drive_nxt;
    logic [31:0]             r_lba, w_lba_nxt;
    logic                    r_op, w_op_nxt;        // 1 = write
    logic [23:0]             r_timer, w_timer_nxt;
    logic                    r_rd, w_rd_nxt;
    logic                    r_wr, w_wr_nxt;
    logic [NUM_DRIVES-1:0]   r_err, w_err_nxt;

    logic [NUM_DRIVES-1:0]   w_req;
    logic                    w_any;
    logic [IDX_W-1:0]        w_grant;
    logic [31:0]             w_lba [NUM_DRIVES];
    logic [7:0]              w_din [NUM_DRIVES];
    logic                    w_xfer;

    assign w_req  = drv_rd | drv_wr;
    assign w_any  = |w_req;
    assign w_xfer = (r_state == S_XFER);

    // Unpack per-drive buses and route host strobes to the granted drive.
    // The strobes are gated by the XFER state so a stray host ack in any
    // other state never reaches a drive.
    for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_port
        assign w_lba[i]       = drv_lba[32*i +: 32];
        assign w_din[i]       = drv_buff_din[8*i +: 8];
        assign drv_ack[i]     = w_xfer && (r_drive == IDX_W'(i)) && sd_ack;
        assign drv_buff_wr[i] = w_xfer && (r_drive == IDX_W'(i)) && sd_buff_wr;
    end

    // Round-robin search: first requesting index at ptr, ptr+1, ... modulo N.
    always_comb begin
        logic             found;
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        w_grant = '0;
        for (int k = 0; k < NUM_DRIVES; k++) begin
            sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_DRIVES))
                sum = sum - (IDX_W+1)'(NUM_DRIVES);
            idx = sum[IDX_W-1:0];
            if (!found && w_req[idx]) begin
                found   = 1'b1;
                w_grant = idx;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_drive_nxt = r_drive;
        w_lba_nxt   = r_lba;
        w_op_nxt    = r_op;
        w_timer_nxt = r_timer;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_err_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_drive_nxt = w_grant;
                    w_lba_nxt   = w_lba[w_grant];
                    // Write wins when a drive raises both requests.
                    w_op_nxt    = drv_wr[w_grant];
                    w_rd_nxt    = ~drv_wr[w_grant];
                    w_wr_nxt    = drv_wr[w_grant];
                    w_timer_nxt = '0;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // The host cannot cancel, so a withdrawn drive request is
                // deliberately not looked at here.
                w_timer_nxt = (r_timer != c_TMR_MAX) ? r_timer + 24'd1 : r_timer;
                if (sd_ack) begin
                    w_state_nxt = S_XFER;
                end else if ((TIMEOUT != 0) && (r_timer == c_TO_LAST)) begin
                    w_err_nxt[r_drive] = 1'b1;
                    w_state_nxt        = S_DONE;
                end else begin
                    w_rd_nxt = ~r_op;
                    w_wr_nxt = r_op;
                end
            end
            S_XFER: begin
                if (!sd_ack)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // Advance past the drive just served; the extra cycle also
                // lets that drive see its ack fall before re-arbitration.
                if (r_drive == IDX_W'(NUM_DRIVES - 1))
                    w_ptr_nxt = '0;
                else
                    w_ptr_nxt = r_drive + IDX_W'(1);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_drive <= '0;
            r_lba   <= '0;
            r_op    <= 1'b0;
            r_timer <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_drive <= w_drive_nxt;
            r_lba   <= w_lba_nxt;
            r_op    <= w_op_nxt;
            r_timer <= w_timer_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign sd_lba      = r_lba;
    assign sd_rd       = r_rd;
    assign sd_wr       = r_wr;
    assign sd_drive    = r_drive;
    assign sd_busy     = (r_state != S_IDLE);
    assign drv_err     = r_err;
    assign sd_buff_din = w_din[r_drive];

endmodule
`default_nettype wire

// File: tb/tb_c1541_sd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c1541_sd_arb
//  Description : Directed self-checking bench for c1541_sd_arb (4 drives,
//                16-cycle host timeout). The initial block plays the host.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_c1541_sd_arb;

    logic         clk_sys = 1'b0;
    logic         reset_n = 1'b0;
    logic [127:0] drv_lba = '0;
    logic [3:0]   drv_rd = '0;
    logic [3:0]   drv_wr = '0;
    logic [3:0]   drv_ack;
    logic [3:0]   drv_buff_wr;
    logic [31:0]  drv_buff_din = '0;
    logic [3:0]   drv_err;
    logic [31:0]  sd_lba;
    logic         sd_rd;
    logic         sd_wr;
    logic         sd_ack = 1'b0;
    logic         sd_buff_wr = 1'b0;
    logic [7:0]   sd_buff_din;
    logic [1:0]   sd_drive;
    logic         sd_busy;

    int total = 0;
    int bad   = 0;

    c1541_sd_arb #(.NUM_DRIVES(4), .IDX_W(2), .TIMEOUT(16)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .drv_lba      (drv_lba),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_ack      (drv_ack),
        .drv_buff_wr  (drv_buff_wr),
        .drv_buff_din (drv_buff_din),
        .drv_err      (drv_err),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .sd_drive     (sd_drive),
        .sd_busy      (sd_busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the host request to appear.
    task automatic wait_req();
        int n;
        n = 0;
        while (!(sd_rd || sd_wr) && n < 30) begin
            tick();
            n++;
        end
        chk("wait_req", {31'd0, sd_rd | sd_wr}, 32'd1);
    endtask

    // Host side of a short transfer for drive d: ack, drive drops its
    // request on ack, ack held ncyc cycles, then DONE and back to IDLE.
    task automatic serve(input int d, input int ncyc);
        sd_ack = 1'b1;
        tick();                                   // now XFER
        chk("xfer_ack", {28'd0, drv_ack}, 32'd1 << d);
        drv_rd[d] = 1'b0;
        drv_wr[d] = 1'b0;
        for (int c = 1; c < ncyc; c++) tick();
        sd_ack = 1'b0;
        tick();                                   // DONE
        tick();                                   // IDLE
    endtask

    initial begin
        int cnt;
        int n;
        logic [1:0] seq [4];
        seq[0] = 2'd1; seq[1] = 2'd0; seq[2] = 2'd1; seq[3] = 2'd0;

        // ---------------- reset state
        tick();
        tick();
        chk("rst_busy", {31'd0, sd_busy}, 32'd0);
        chk("rst_rdwr", {30'd0, sd_rd, sd_wr}, 32'd0);
        chk("rst_lba", sd_lba, 32'd0);
        chk("rst_drive", {30'd0, sd_drive}, 32'd0);
        chk("rst_acks", {20'd0, drv_ack, drv_buff_wr, drv_err}, 32'd0);
        reset_n = 1'b1;
        tick();

        // ---------------- single read on drive 2
        drv_lba[64 +: 32] = 32'd357;
        drv_rd[2] = 1'b1;
        #1;
        chk("idle_no_rd", {31'd0, sd_rd}, 32'd0);
        tick();
        chk("rd_sd_rd", {30'd0, sd_rd, sd_wr}, 32'd2);
        chk("rd_lba", sd_lba, 32'd357);
        chk("rd_drive", {30'd0, sd_drive}, 32'd2);
        chk("rd_busy", {31'd0, sd_busy}, 32'd1);
        chk("req_no_ack", {28'd0, drv_ack}, 32'd0);
        sd_ack = 1'b1;
        tick();
        chk("rd_ack2", {28'd0, drv_ack}, 32'h4);
        chk("rd_drop", {30'd0, sd_rd, sd_wr}, 32'd0);
        drv_rd[2] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 512; i++) begin
            sd_buff_wr = 1'b1;
            #1;
            if (drv_buff_wr == 4'b0100) cnt++;
            sd_buff_wr = 1'b0;
            #1;
            if (drv_buff_wr != 4'b0000) cnt = cnt + 1000;
            tick();
        end
        chk("rd_strobes", cnt, 32'd512);
        sd_ack = 1'b0;
        tick();
        chk("done_busy", {31'd0, sd_busy}, 32'd1);
        chk("done_ack", {28'd0, drv_ack}, 32'd0);
        tick();
        chk("back_idle", {31'd0, sd_busy}, 32'd0);

        // ---------------- wrap: ptr=3, requests on 0 and 3
        drv_lba[0 +: 32]  = 32'd10;
        drv_lba[96 +: 32] = 32'd30;
        drv_rd[0] = 1'b1;
        drv_rd[3] = 1'b1;
        tick();
        chk("wrap_first", {30'd0, sd_drive}, 32'd3);
        chk("wrap_lba3", sd_lba, 32'd30);
        serve(3, 3);
        wait_req();
        chk("wrap_second", {30'd0, sd_drive}, 32'd0);
        chk("wrap_lba0", sd_lba, 32'd10);
        serve(0, 2);

        // ---------------- fairness between drives 0 and 1 (ptr=1)
        drv_rd[0] = 1'b1;
        drv_rd[1] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_req();
            chk("fair_grant", {30'd0, sd_drive}, {30'd0, seq[g]});
            sd_ack = 1'b1;
            tick();
            drv_rd[seq[g]] = 1'b0;
            tick();
            sd_ack = 1'b0;
            tick();                                // DONE
            drv_rd[seq[g]] = (g < 2);              // keep requesting until the end
            tick();                                // IDLE
        end
        drv_rd = '0;
        tick();

        // ---------------- read+write on drive 1 (ptr=1)
        drv_buff_din = 32'h44_33_A5_11;
        drv_rd[1] = 1'b1;
        drv_wr[1] = 1'b1;
        tick();
        chk("rw_wr_wins", {30'd0, sd_rd, sd_wr}, 32'd1);
        chk("rw_drive", {30'd0, sd_drive}, 32'd1);
        chk("rw_din", {24'd0, sd_buff_din}, 32'hA5);
        drv_buff_din[15:8] = 8'h5A;
        #1;
        chk("rw_din2", {24'd0, sd_buff_din}, 32'h5A);
        serve(1, 4);

        // ---------------- timeout on drive 3 (ptr=2)
        drv_wr[3] = 1'b1;
        tick();
        cnt = 0;
        n = 0;
        while (sd_wr && n < 40) begin
            cnt++;
            n++;
            tick();
        end
        drv_wr[3] = 1'b0;
        chk("to_wr_cycles", cnt, 32'd16);
        chk("to_err", {28'd0, drv_err}, 32'h8);
        chk("to_busy", {31'd0, sd_busy}, 32'd1);
        tick();
        chk("to_err_pulse", {28'd0, drv_err}, 32'd0);
        chk("to_idle", {31'd0, sd_busy}, 32'd0);

        // ---------------- stray ack in IDLE
        sd_ack = 1'b1;
        sd_buff_wr = 1'b1;
        #1;
        chk("stray_ack", {28'd0, drv_ack, drv_buff_wr}, 32'd0);
        tick();
        chk("stray_idle", {31'd0, sd_busy}, 32'd0);
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        tick();

        // ---------------- ptr=0 after timeout, then reset mid-XFER
        drv_rd[1] = 1'b1;
        drv_rd[3] = 1'b1;
        tick();
        chk("post_to_grant", {30'd0, sd_drive}, 32'd1);
        sd_ack = 1'b1;
        tick();
        sd_buff_wr = 1'b1;
        #1;
        chk("xfer_bwr", {28'd0, drv_buff_wr}, 32'h2);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, sd_busy}, 32'd0);
        chk("arst_strobes", {28'd0, drv_ack, drv_buff_wr}, 32'd0);
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        drv_rd = '0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
